// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin decoder arbiter.
//   - state_t : arbiter state encoding (ST_IDLE / ST_GRANT)
//   - NUM_REQ : number of requesters sharing the resource
//   - pick()  : round-robin selection, scanning upward from the slot after p
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Returns the first set bit of v when scanning p+1, p+2, p+3, p (mod 4).
  // When v is empty it returns p; callers only use the result when v != 0.
  function automatic logic [1:0] pick(input logic [NUM_REQ-1:0] v,
                                      input logic [1:0]         p);
    logic [1:0] idx;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = p + 2'(k);
      if (!found && v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/two_to_four_decoder.sv
// Plain 2-to-4 line decoder; a is the MSB, b is the LSB of the select.
// Ports:
//   a, b   : select inputs
//   d0..d3 : one-hot decoded outputs (d<n> high when {a,b} == n)
module two_to_four_decoder (
  input  logic a,
  input  logic b,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3
);

  assign d0 = ~a & ~b;
  assign d1 = ~a &  b;
  assign d2 =  a & ~b;
  assign d3 =  a &  b;

endmodule

// File: rtl/rr_decoder_arbiter.sv
// 4-requester round-robin arbiter. The winner is kept as a registered 2-bit
// index and turned into a one-hot grant by the shared 2-to-4 decoder, so the
// grant comes straight from flops and is glitch-free. Ownership is
// non-preemptive: an owner keeps the resource until it drops its request.
//
// Optional feature, macro ARB_TIMEOUT_EN: an owner that holds the grant for
// MAX_HOLD consecutive cycles is forcibly released and must re-win
// arbitration. Without the macro, timeout is tied low and the hold counter
// does not exist.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   req     : request vector, bit i belongs to requester i
//   gnt     : one-hot grant, all zero when nobody owns the resource
//   gnt_idx : index of the current owner (held while idle)
//   busy    : high while a grant is active
//   timeout : one-cycle pulse after a forced release
module rr_decoder_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_idx,
  output logic               busy,
  output logic               timeout
);

  // Reject illegal configurations at elaboration time.
  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (1 << CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_decoder_arbiter: MAX_HOLD must be 2..255 and fit in CNT_W bits");
  end

  state_t             state;
  logic [1:0]         ptr;
  logic               owner_req;
  logic [NUM_REQ-1:0] others;
  logic               d0, d1, d2, d3;

  // Owner's own request bit, and every other pending request.
  assign owner_req = req[gnt_idx];
  assign others    = req & ~(4'b0001 << gnt_idx);

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_expired;

  // Last allowed cycle of the current ownership.
  assign hold_expired = owner_req && (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
  assign timeout = 1'b0;
`endif

  // Arbiter FSM: IDLE picks a winner as soon as anyone requests; GRANT holds
  // the owner and hands over directly to the next requester on release.
  // ptr remembers the last served requester so the scan starts just past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      gnt_idx <= 2'b00;
      ptr     <= 2'b11;
`ifdef ARB_TIMEOUT_EN
      timeout  <= 1'b0;
      hold_cnt <= '0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt_idx <= pick(req, ptr);
            busy    <= 1'b1;
            state   <= ST_GRANT;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        ST_GRANT: begin
`ifdef ARB_TIMEOUT_EN
          // Forced release: the evicted owner is masked out of this pick.
          if (hold_expired) begin
            timeout  <= 1'b1;
            ptr      <= gnt_idx;
            hold_cnt <= '0;
            if (|others) begin
              gnt_idx <= pick(others, gnt_idx);
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else
`endif
          if (owner_req) begin
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt + CNT_W'(1);
`endif
          end else begin
            ptr <= gnt_idx;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
            if (|others) begin
              gnt_idx <= pick(others, gnt_idx);
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  two_to_four_decoder u_dec (
    .a  (gnt_idx[1]),
    .b  (gnt_idx[0]),
    .d0 (d0),
    .d1 (d1),
    .d2 (d2),
    .d3 (d3)
  );

  assign gnt = {d3, d2, d1, d0} & {NUM_REQ{busy}};

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Self-checking bench for rr_decoder_arbiter: a table of directed vectors
// (request in, expected grant state out) plus hand-written sequences for
// asynchronous reset and long-hold behaviour with and without ARB_TIMEOUT_EN.
module tb_rr_decoder_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 4;
`else
  localparam int TB_MAX_HOLD = 16;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       rst_before;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] idx;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];

  rr_decoder_arbiter #(
    .MAX_HOLD (TB_MAX_HOLD),
    .CNT_W    (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive req, let one rising edge sample it, then settle just after the edge.
  task automatic applyStimulus(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg,
                             input logic eb, input logic [1:0] ei,
                             input logic et);
    n_checks++;
    if (gnt !== eg || busy !== eb || gnt_idx !== ei || timeout !== et) begin
      n_fail++;
      $display("[TB] FAIL %s: got gnt=%b busy=%b idx=%0d timeout=%b, expected gnt=%b busy=%b idx=%0d timeout=%b",
               name, gnt, busy, gnt_idx, timeout, eg, eb, ei, et);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    req = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic rb, input logic [3:0] r,
                              input logic [3:0] g, input logic b,
                              input logic [1:0] i);
    vec_t v;
    v.rst_before = rb;
    v.req        = r;
    v.gnt        = g;
    v.busy       = b;
    v.idx        = i;
    v.tmo        = 1'b0;
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req      = 4'b0000;
    #2;
    checkOutput("reset_values", 4'b0000, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;

    // Single requester from reset, then release to idle.
    vecs.push_back(mk(1, 4'b0001, 4'b0001, 1, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 2'd0));
    // All four requesting: order 0,1,2,3,0 with 3-cycle ownerships.
    vecs.push_back(mk(1, 4'b1111, 4'b0001, 1, 2'd0));
    vecs.push_back(mk(0, 4'b1111, 4'b0001, 1, 2'd0));
    vecs.push_back(mk(0, 4'b1111, 4'b0001, 1, 2'd0));
    vecs.push_back(mk(0, 4'b1110, 4'b0010, 1, 2'd1));
    vecs.push_back(mk(0, 4'b1111, 4'b0010, 1, 2'd1));
    vecs.push_back(mk(0, 4'b1111, 4'b0010, 1, 2'd1));
    vecs.push_back(mk(0, 4'b1101, 4'b0100, 1, 2'd2));
    vecs.push_back(mk(0, 4'b1111, 4'b0100, 1, 2'd2));
    vecs.push_back(mk(0, 4'b1111, 4'b0100, 1, 2'd2));
    vecs.push_back(mk(0, 4'b1011, 4'b1000, 1, 2'd3));
    vecs.push_back(mk(0, 4'b1111, 4'b1000, 1, 2'd3));
    vecs.push_back(mk(0, 4'b1111, 4'b1000, 1, 2'd3));
    vecs.push_back(mk(0, 4'b0111, 4'b0001, 1, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 2'd0));
    // Owner 2 holds while 0 and 3 arrive; 3 is served before 0.
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 2'd2));
    vecs.push_back(mk(0, 4'b1101, 4'b0100, 1, 2'd2));
    vecs.push_back(mk(0, 4'b1001, 4'b1000, 1, 2'd3));
    vecs.push_back(mk(0, 4'b1001, 4'b1000, 1, 2'd3));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 2'd0));
    // Index is held while idle.
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 1, 2'd3));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 2'd3));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 2'd3));
    // Requester 2 drops before it is granted and is never selected.
    vecs.push_back(mk(0, 4'b0110, 4'b0010, 1, 2'd1));
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 1, 2'd1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 2'd1));

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) resetDut();
      applyStimulus(vecs[i].req);
      checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].busy,
                  vecs[i].idx, vecs[i].tmo);
    end

    // Asynchronous reset mid-grant: move ptr to 1, grant owner 2, then reset
    // between edges. After release the scan must start from requester 0.
    resetDut();
    applyStimulus(4'b0010);
    applyStimulus(4'b0000);
    applyStimulus(4'b0100);
    checkOutput("pre_async_owner2", 4'b0100, 1'b1, 2'd2, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_immediate", 4'b0000, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    req = 4'b0000;
    rst = 1'b0;
    applyStimulus(4'b1010);
    checkOutput("post_reset_ptr", 4'b0010, 1'b1, 2'd1, 1'b0);
    applyStimulus(4'b1000);
    checkOutput("post_reset_owner3", 4'b1000, 1'b1, 2'd3, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Two requesters holding forever: 4-cycle ownerships alternate with a
    // timeout pulse in the first cycle of each new owner.
    resetDut();
    for (int k = 1; k <= 12; k++) begin
      int   own;
      logic tp;
      own = ((k - 1) / TB_MAX_HOLD) % 2;
      tp  = (k > 1) && (((k - 1) % TB_MAX_HOLD) == 0);
      applyStimulus(4'b0011);
      checkOutput($sformatf("timeout_pair_k%0d", k),
                  (own == 1) ? 4'b0010 : 4'b0001, 1'b1, 2'(own), tp);
    end
    // Lone requester is evicted to idle, then re-wins on the next edge.
    resetDut();
    for (int k = 1; k <= TB_MAX_HOLD; k++) begin
      applyStimulus(4'b0001);
      checkOutput($sformatf("timeout_solo_k%0d", k), 4'b0001, 1'b1, 2'd0, 1'b0);
    end
    applyStimulus(4'b0001);
    checkOutput("timeout_solo_evict", 4'b0000, 1'b0, 2'd0, 1'b1);
    applyStimulus(4'b0001);
    checkOutput("timeout_solo_regrant", 4'b0001, 1'b1, 2'd0, 1'b0);
`else
    // Without the timeout feature a single owner keeps the grant indefinitely.
    resetDut();
    for (int k = 1; k <= 100; k++) begin
      applyStimulus(4'b0001);
      checkOutput($sformatf("long_hold_k%0d", k), 4'b0001, 1'b1, 2'd0, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
